// File: rtl/scan_pkg.sv
// Shared definitions for the channel scan sequencer: channel geometry and
// the sequencer state encoding.
package scan_pkg;

  localparam int NUM_CH = 16;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/scan_next_ch.sv
// Priority search for the next enabled channel: lowest set mask bit, either
// from bit 0 (from_zero) or strictly above the current address.
module scan_next_ch
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [ADDR_W-1:0] addr,
  input  logic              from_zero,
  output logic              found,
  output logic [ADDR_W-1:0] ch
);

  // Descending walk so the lowest qualifying bit is the last one written.
  always_comb begin
    found = 1'b0;
    ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (from_zero || (i > int'(addr)))) begin
        found = 1'b1;
        ch    = ADDR_W'(i);
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Sequential channel scanner driving a 4-to-16 one-hot decoder's select/enable.
// Define SCAN_BLANKING_EN to insert one en=0 BLANK cycle between channels.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [NUM_CH-1:0]  mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [ADDR_W-1:0]  addr,
  output logic               en,
  output logic               busy,
  output logic               done
);

  state_t             state, state_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic [DWELL_W-1:0] dwell_eff;
  logic               stop_q, stop_eff;
  logic               done_d;
  logic               adv_found, wrap_found, has_above;
  logic [ADDR_W-1:0]  adv_ch, wrap_ch;

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign stop_eff  = stop_q | stop;

  scan_next_ch u_adv (
    .mask      (mask),
    .addr      (addr),
    .from_zero (1'b0),
    .found     (adv_found),
    .ch        (adv_ch)
  );

  scan_next_ch u_wrap (
    .mask      (mask),
    .addr      (addr),
    .from_zero (1'b1),
    .found     (wrap_found),
    .ch        (wrap_ch)
  );

  // done is registered, so "last channel of the sweep" is decided one cycle
  // ahead, against the channel that will be driven next cycle.
  assign has_above = |((mask >> addr_d) >> 1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state;
    addr_d  = addr;
    cnt_d   = cnt;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          if (wrap_found) begin
            state_d = DWELL;
            addr_d  = wrap_ch;
            cnt_d   = dwell_eff;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      DWELL: begin
        if (cnt > DWELL_W'(1)) begin
          cnt_d = cnt - DWELL_W'(1);
        end else if (stop_eff) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (adv_found || (cont && wrap_found)) begin
          addr_d = adv_found ? adv_ch : wrap_ch;
`ifdef SCAN_BLANKING_EN
          state_d = BLANK;
          cnt_d   = '0;
`else
          cnt_d   = dwell_eff;
`endif
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      BLANK: begin
        state_d = DWELL;
        cnt_d   = dwell_eff;
      end
      default: state_d = IDLE;
    endcase
    if ((state_d == DWELL) && (cnt_d == DWELL_W'(1)) && !has_above) done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr   <= '0;
      cnt    <= '0;
      stop_q <= 1'b0;
      en     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state  <= state_d;
      addr   <= addr_d;
      cnt    <= cnt_d;
      stop_q <= (state_d != IDLE) && (stop_q || stop);
      en     <= (state_d == DWELL);
      busy   <= (state_d != IDLE);
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: a channel-list model expands each sweep
// into expected per-cycle outputs; a negedge monitor pops and compares them.
module tb_scan_sequencer;

  localparam int DWELL_W = 8;
`ifdef SCAN_BLANKING_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] addr;
    logic       en;
    logic       busy;
    logic       done;
  } obs_t;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic               cont;
  logic [15:0]        mask;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         addr;
  logic               en;
  logic               busy;
  logic               done;

  int         n_cmp = 0;
  int         n_err = 0;
  obs_t       exp_q[$];
  obs_t       trace[$];
  logic [3:0] last_addr = 4'd0;
  string      cur_name = "none";
  int         mon_idx = 0;

  scan_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .cont  (cont),
    .mask  (mask),
    .dwell (dwell),
    .addr  (addr),
    .en    (en),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic obs_t mk(input logic [3:0] a, input logic e, input logic b, input logic d);
    obs_t o;
    o.addr = a;
    o.en   = e;
    o.busy = b;
    o.done = d;
    return o;
  endfunction

  // Expected outputs per cycle; entry 0 is the cycle in which start is driven,
  // s is the cycle index in which stop is driven (-1 = never).
  task automatic build(input logic [15:0] m, input int d, input bit c, input int s);
    int         deff;
    int         chans[$];
    bit         first;
    logic [3:0] a;
    trace.delete();
    deff = (d == 0) ? 1 : d;
    for (int i = 0; i < 16; i++) if (m[i]) chans.push_back(i);
    trace.push_back(mk(last_addr, 1'b0, 1'b0, 1'b0));
    if (s == 0) begin
      trace.push_back(mk(last_addr, 1'b0, 1'b0, 1'b0));
      trace.push_back(mk(last_addr, 1'b0, 1'b0, 1'b0));
      return;
    end
    if (chans.size() == 0) begin
      trace.push_back(mk(last_addr, 1'b0, 1'b0, 1'b1));
      trace.push_back(mk(last_addr, 1'b0, 1'b0, 1'b0));
      return;
    end
    first = 1'b1;
    while (trace.size() < 3000) begin
      foreach (chans[n]) begin
        a = 4'(chans[n]);
        if (!first && BLANK_EN) trace.push_back(mk(a, 1'b0, 1'b1, 1'b0));
        first = 1'b0;
        for (int j = 0; j < deff; j++)
          trace.push_back(mk(a, 1'b1, 1'b1, (n == chans.size() - 1) && (j == deff - 1)));
        if ((s >= 1) && (s <= trace.size() - 1)) begin
          trace.push_back(mk(a, 1'b0, 1'b0, 1'b0));
          last_addr = a;
          return;
        end
      end
      if (!c) begin
        trace.push_back(mk(a, 1'b0, 1'b0, 1'b0));
        last_addr = a;
        return;
      end
    end
  endtask

  task automatic run(input string nm, input logic [15:0] m, input int d, input bit c, input int s);
    build(m, d, c, s);
    @(posedge clk); #1;
    cur_name = nm;
    mon_idx  = 0;
    foreach (trace[k]) exp_q.push_back(trace[k]);
    mask  = m;
    dwell = DWELL_W'(d);
    cont  = c;
    start = 1'b1;
    stop  = (s == 0);
    for (int k = 1; k < trace.size(); k++) begin
      @(posedge clk); #1;
      start = trace[k].busy && ($urandom_range(0, 3) == 0);
      stop  = trace[k].busy && (k == s);
    end
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  always @(negedge clk) begin
    obs_t e;
    obs_t g;
    if (rst_n && (exp_q.size() > 0)) begin
      e = exp_q.pop_front();
      g = mk(addr, en, busy, done);
      check($sformatf("%s cyc%0d {addr,en,busy,done}", cur_name, mon_idx), 32'(g), 32'(e));
      mon_idx++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] m;
    int          d;
    bit          c;
    int          s;
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    cont  = 1'b0;
    mask  = '0;
    dwell = '0;
    #2;
    check("reset addr", 32'(addr), 0);
    check("reset en",   32'(en),   0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run("empty_mask", 16'h0000, 3, 1'b0, -1);
    run("sweep_8421", 16'h8421, 3, 1'b0, -1);
    run("start_stop_same", 16'h0040, 2, 1'b0, 0);
    run("wrap_0003", 16'h0003, 0, 1'b1, 9);
    run("stop_mid_ch2", 16'h0016, 5, 1'b0, BLANK_EN ? 8 : 7);
    run("top_only_cont", 16'h8000, 2, 1'b1, 7);

    for (int r = 0; r < 24; r++) begin
      m = 16'($urandom);
      if ($urandom_range(0, 1) == 1) m = m & 16'($urandom) & 16'($urandom);
      if (r == 5) m = 16'h0000;
      d = $urandom_range(0, 4);
      c = 1'($urandom_range(0, 1));
      if (c) s = $urandom_range(1, 40);
      else   s = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : -1;
      run($sformatf("rand%0d", r), m, d, c, s);
    end

    // Asynchronous reset in the middle of a dwell.
    @(posedge clk); #1;
    mask  = 16'h0f00;
    dwell = DWELL_W'(10);
    cont  = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset en",   32'(en),   1);
    check("pre_reset addr", 32'(addr), 8);
    rst_n = 1'b0;
    #1;
    check("async_reset addr", 32'(addr), 0);
    check("async_reset en",   32'(en),   0);
    check("async_reset busy", 32'(busy), 0);
    check("async_reset done", 32'(done), 0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    last_addr = 4'd0;
    run("after_reset_0010", 16'h0010, 2, 1'b0, -1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
